xcorr_ifft_peak: RTL and testbench

Frame-level peak detector on the receive correlator, downstream of the IFFT subsystem. It consumes the block-floating-point IFFT output stream: I/Q, block exponent, valid and end-of-frame. It computes per-sample power and tracks the per-frame maximum and its index. At each frame end it emits one result word with a threshold-based detection flag.

---
 rtl/xcorr_ifft_peak_if.sv | 31 +++
 rtl/xcorr_ifft_peak.sv | 200 ++++++++++++++++++++
 tb/tb_xcorr_ifft_peak.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xcorr_ifft_peak_if.sv
// Sample stream from the block-floating-point IFFT and the per-frame peak result.
// The slave side is the peak detector; the master side drives samples and reads results.
`timescale 1ns/1ps
interface xcorr_ifft_peak_if #(
  parameter int IDX_W  = 10,
  parameter int DATA_W = 16
);
  logic                     ival;
  logic signed [DATA_W-1:0] data_i;
  logic signed [DATA_W-1:0] data_q;
  logic [4:0]               iexp;
  logic                     ieop;
  logic [7:0]               thr;

  logic                     ores_val;
  logic [2*DATA_W:0]        opeak_pow;
  logic [IDX_W-1:0]         opeak_idx;
  logic [4:0]               oexp;
  logic                     odet;
  logic                     oerr;

  modport master (
    output ival, data_i, data_q, iexp, ieop, thr,
    input  ores_val, opeak_pow, opeak_idx, oexp, odet, oerr
  );

  modport slave (
    input  ival, data_i, data_q, iexp, ieop, thr,
    output ores_val, opeak_pow, opeak_idx, oexp, odet, oerr
  );
endinterface

// File: rtl/xcorr_ifft_peak.sv
// Per-frame power peak detector on the IFFT output: tracks max |x|^2 and its index,
// then flags detection when the peak exceeds thr (Q4.4) times the frame's average power.
`timescale 1ns/1ps
module xcorr_ifft_peak #(
  parameter int FFT_LEN = 1024,
  parameter int IDX_W   = 10,
  parameter int DATA_W  = 16
) (
  input logic          clk,
  input logic          rst_n,
  xcorr_ifft_peak_if.slave bus
);

  localparam int POW_W = 2*DATA_W + 1;
  localparam int SUM_W = POW_W + IDX_W;
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(FFT_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_LEN - 1);

  function automatic logic [POW_W-1:0] power(input logic signed [DATA_W-1:0] a,
                                             input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ax, bx, aa, bb;
    ax = {{DATA_W{a[DATA_W-1]}}, a};
    bx = {{DATA_W{b[DATA_W-1]}}, b};
    aa = ax * ax;
    bb = bx * bx;
    return {1'b0, $unsigned(aa)} + {1'b0, $unsigned(bb)};
  endfunction

  // peak * FFT_LEN * 16 against sum * thr, both held at full width
  function automatic logic detect(input logic [POW_W-1:0] pk,
                                  input logic [SUM_W-1:0] s,
                                  input logic [7:0]       t);
    logic [SUM_W+7:0] lhs, s_x, t_x;
    lhs = {4'b0, pk, {IDX_W{1'b0}}, 4'b0};
    s_x = {8'b0, s};
    t_x = {{SUM_W{1'b0}}, t};
    return lhs > (s_x * t_x);
  endfunction

  // ---- S0: input register ----
  logic                     vld_p0, eop_p0;
  logic signed [DATA_W-1:0] di_p0, dq_p0;
  logic [4:0]               exp_p0;
  logic [7:0]               thr_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      eop_p0 <= 1'b0;
    end else begin
      vld_p0 <= bus.ival;
      eop_p0 <= bus.ieop;
    end
  end

  always_ff @(posedge clk) begin
    di_p0  <= bus.data_i;
    dq_p0  <= bus.data_q;
    exp_p0 <= bus.iexp;
    thr_p0 <= bus.thr;
  end

  // ---- S1: power ----
  logic             vld_p1, eop_p1;
  logic [POW_W-1:0] pow_p1;
  logic [4:0]       exp_p1;
  logic [7:0]       thr_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      eop_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      eop_p1 <= eop_p0;
    end
  end

  always_ff @(posedge clk) begin
    pow_p1 <= power(di_p0, dq_p0);
    exp_p1 <= exp_p0;
    thr_p1 <= thr_p0;
  end

  // ---- S2: frame accumulation and close ----
  logic             first_acc;
  logic [POW_W-1:0] max_acc, nx_max;
  logic [IDX_W-1:0] idx_acc, nx_idx;
  logic [SUM_W-1:0] sum_acc, nx_sum;
  logic [4:0]       exp_acc, nx_exp;
  logic             err_acc, nx_err;
  logic [IDX_W:0]   cnt_acc, nx_cnt;
  logic             cnt_full;

  assign cnt_full = (cnt_acc == CNT_FULL);

  always_comb begin
    nx_max = max_acc;
    nx_idx = idx_acc;
    nx_sum = sum_acc;
    nx_exp = exp_acc;
    nx_err = err_acc;
    nx_cnt = cnt_acc;
    if (first_acc) begin
      nx_max = pow_p1;
      nx_idx = '0;
      nx_sum = {{IDX_W{1'b0}}, pow_p1};
      nx_exp = exp_p1;
      nx_err = 1'b0;
      nx_cnt = (IDX_W+1)'(1);
    end else begin
      // samples beyond FFT_LEN still compete for the peak but report the last legal index
      if (pow_p1 > max_acc) begin
        nx_max = pow_p1;
        nx_idx = cnt_full ? IDX_LAST : cnt_acc[IDX_W-1:0];
      end
      nx_sum = sum_acc + {{IDX_W{1'b0}}, pow_p1};
      nx_cnt = cnt_full ? cnt_acc : cnt_acc + 1'b1;
      nx_err = err_acc | cnt_full | (exp_p1 != exp_acc);
    end
  end

  logic             vld_p2;
  logic [POW_W-1:0] max_p2;
  logic [IDX_W-1:0] idx_p2;
  logic [SUM_W-1:0] sum_p2;
  logic [4:0]       exp_p2;
  logic             err_p2;
  logic [7:0]       thr_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_acc <= 1'b1;
      max_acc   <= '0;
      idx_acc   <= '0;
      sum_acc   <= '0;
      exp_acc   <= '0;
      err_acc   <= 1'b0;
      cnt_acc   <= '0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p2 <= vld_p1 & eop_p1;
      if (vld_p1) begin
        first_acc <= eop_p1;
        max_acc   <= nx_max;
        idx_acc   <= nx_idx;
        sum_acc   <= nx_sum;
        exp_acc   <= nx_exp;
        err_acc   <= nx_err;
        cnt_acc   <= nx_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1 & eop_p1) begin
      max_p2 <= nx_max;
      idx_p2 <= nx_idx;
      sum_p2 <= nx_sum;
      exp_p2 <= nx_exp;
      err_p2 <= nx_err | (nx_cnt != CNT_FULL);
      thr_p2 <= thr_p1;
    end
  end

  // ---- S3: detection decision and result registers ----
  logic             res_val;
  logic [POW_W-1:0] res_pow;
  logic [IDX_W-1:0] res_idx;
  logic [4:0]       res_exp;
  logic             res_det, res_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_val <= 1'b0;
      res_pow <= '0;
      res_idx <= '0;
      res_exp <= '0;
      res_det <= 1'b0;
      res_err <= 1'b0;
    end else begin
      res_val <= vld_p2;
      if (vld_p2) begin
        res_pow <= max_p2;
        res_idx <= idx_p2;
        res_exp <= exp_p2;
        res_det <= detect(max_p2, sum_p2, thr_p2);
        res_err <= err_p2;
      end
    end
  end

  assign bus.ores_val  = res_val;
  assign bus.opeak_pow = res_pow;
  assign bus.opeak_idx = res_idx;
  assign bus.oexp      = res_exp;
  assign bus.odet      = res_det;
  assign bus.oerr      = res_err;

endmodule

// File: tb/tb_xcorr_ifft_peak.sv
// Directed-plus-random bench for xcorr_ifft_peak; expected results come from a
// frame-level model that works on the whole list of samples after each frame.
`timescale 1ns/1ps
module tb_xcorr_ifft_peak;
  localparam int FFT_LEN = 1024;
  localparam int IDX_W   = 10;
  localparam int DATA_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xcorr_ifft_peak_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

  xcorr_ifft_peak #(.FFT_LEN(FFT_LEN), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    longint unsigned pow;
    longint unsigned idx;
    longint unsigned ex;
    longint unsigned det;
    longint unsigned err;
    longint unsigned cyc;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  res_t last_got;
  int checks = 0;
  int failures = 0;
  longint unsigned cyc = 0;
  int si [0:1099];
  int sq [0:1099];
  int se [0:1099];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    res_t r;
    if (bus.ores_val === 1'b1) begin
      r.pow = 64'(bus.opeak_pow);
      r.idx = 64'(bus.opeak_idx);
      r.ex  = 64'(bus.oexp);
      r.det = 64'(bus.odet);
      r.err = 64'(bus.oerr);
      r.cyc = cyc;
      got_q.push_back(r);
    end
  end

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Frame rules: max power (first occurrence wins), total power, exponent consistency, length.
  function automatic void model(input int n, input int t, output res_t r);
    longint unsigned p;
    longint unsigned mx = 0;
    longint unsigned sum = 0;
    int pos = 0;
    bit err = 1'b0;
    for (int k = 0; k < n; k++) begin
      p = longint'(si[k]) * longint'(si[k]) + longint'(sq[k]) * longint'(sq[k]);
      if (k == 0 || p > mx) begin
        mx = p;
        pos = k;
      end
      sum += p;
      if (se[k] != se[0]) err = 1'b1;
    end
    if (n != FFT_LEN) err = 1'b1;
    r.pow = mx;
    r.idx = (pos > FFT_LEN - 1) ? longint'(FFT_LEN - 1) : longint'(pos);
    r.ex  = longint'(se[0]);
    r.det = (mx * FFT_LEN * 16 > sum * longint'(t)) ? 64'd1 : 64'd0;
    r.err = err ? 64'd1 : 64'd0;
    r.cyc = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bus.ival   = 1'b0;
      bus.ieop   = 1'($urandom_range(1));
      bus.data_i = 16'($urandom);
      bus.data_q = 16'($urandom);
      tick();
    end
    bus.ival = 1'b0;
    bus.ieop = 1'b0;
  endtask

  task automatic fill(input int n, input int amp, input int e);
    for (int k = 0; k < n; k++) begin
      si[k] = int'($urandom_range(2*amp)) - amp;
      sq[k] = int'($urandom_range(2*amp)) - amp;
      se[k] = e;
    end
  endtask

  task automatic send_frame(input int n, input int duty, input int t, input bit with_eop);
    res_t r;
    model(n, t, r);
    bus.thr = 8'(t);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && int'($urandom_range(99)) >= duty) idle(1);
      bus.ival   = 1'b1;
      bus.data_i = 16'(si[k]);
      bus.data_q = 16'(sq[k]);
      bus.iexp   = 5'(se[k]);
      bus.ieop   = with_eop && (k == n - 1);
      if (bus.ieop) begin
        r.cyc = cyc + 3 + 1;
        exp_q.push_back(r);
      end
      tick();
    end
  endtask

  task automatic check_next(input string tag);
    res_t e;
    res_t g;
    int w = 0;
    while (got_q.size() == 0 && w < 200) begin
      tick();
      w++;
    end
    e = exp_q.pop_front();
    if (got_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=no_result expected=result", tag);
    end else begin
      g = got_q.pop_front();
      last_got = g;
      chk({tag, "_pow"}, g.pow, e.pow);
      chk({tag, "_idx"}, g.idx, e.idx);
      chk({tag, "_exp"}, g.ex,  e.ex);
      chk({tag, "_det"}, g.det, e.det);
      chk({tag, "_err"}, g.err, e.err);
      chk({tag, "_latency"}, g.cyc, e.cyc);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_val"}, 64'(bus.ores_val),  64'd0);
    chk({tag, "_pow"}, 64'(bus.opeak_pow), 64'd0);
    chk({tag, "_idx"}, 64'(bus.opeak_idx), 64'd0);
    chk({tag, "_exp"}, 64'(bus.oexp),      64'd0);
    chk({tag, "_det"}, 64'(bus.odet),      64'd0);
    chk({tag, "_err"}, 64'(bus.oerr),      64'd0);
  endtask

  initial begin
    bus.ival = 1'b0; bus.ieop = 1'b0; bus.data_i = '0; bus.data_q = '0;
    bus.iexp = '0;   bus.thr = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle(3);

    // single dominant peak
    for (int k = 0; k < FFT_LEN; k++) begin si[k] = 1; sq[k] = 1; se[k] = 3; end
    si[300] = 1000; sq[300] = -1000;
    send_frame(FFT_LEN, 100, 'h40, 1'b1);
    idle(2);
    check_next("peak");
    chk("peak_pow_abs", last_got.pow, 64'd2000000);
    chk("peak_idx_abs", last_got.idx, 64'd300);
    chk("peak_exp_abs", last_got.ex,  64'd3);
    chk("peak_det_abs", last_got.det, 64'd1);
    chk("peak_err_abs", last_got.err, 64'd0);

    // flat frame, ties keep index 0
    for (int k = 0; k < FFT_LEN; k++) begin si[k] = 100; sq[k] = 0; se[k] = 0; end
    send_frame(FFT_LEN, 100, 'h20, 1'b1);
    idle(2);
    check_next("flat");
    chk("flat_idx_abs", last_got.idx, 64'd0);
    chk("flat_pow_abs", last_got.pow, 64'd10000);
    chk("flat_det_abs", last_got.det, 64'd0);

    // 50% valid duty
    fill(FFT_LEN, 200, 7);
    si[5] = 6000; sq[5] = -3000;
    send_frame(FFT_LEN, 50, int'($urandom_range(255)), 1'b1);
    idle(2);
    check_next("gap");
    chk("gap_idx_abs", last_got.idx, 64'd5);

    // back-to-back frames
    fill(FFT_LEN, 200, 9);
    si[5] = -7000; sq[5] = 2000;
    send_frame(FFT_LEN, 100, int'($urandom_range(255)), 1'b1);
    fill(FFT_LEN, 200, 10);
    si[1023] = 5000; sq[1023] = 5000;
    send_frame(FFT_LEN, 100, int'($urandom_range(255)), 1'b1);
    idle(2);
    check_next("b2b_a");
    chk("b2b_a_idx_abs", last_got.idx, 64'd5);
    check_next("b2b_b");
    chk("b2b_b_idx_abs", last_got.idx, 64'd1023);

    // short frame: eop on sample 999
    fill(1000, 300, 2);
    si[100] = 4000;
    send_frame(1000, 75, int'($urandom_range(255)), 1'b1);
    idle(2);
    check_next("short");
    chk("short_err_abs", last_got.err, 64'd1);

    // long frame: 1030 samples
    fill(1030, 300, 4);
    si[600] = 4000;
    send_frame(1030, 100, int'($urandom_range(255)), 1'b1);
    idle(2);
    check_next("long");
    chk("long_err_abs", last_got.err, 64'd1);
    chk("long_idx_range", (last_got.idx <= 64'd1023) ? 64'd1 : 64'd0, 64'd1);

    // exponent change mid-frame
    fill(FFT_LEN, 300, 6);
    for (int k = 500; k < FFT_LEN; k++) se[k] = 11;
    send_frame(FFT_LEN, 100, int'($urandom_range(255)), 1'b1);
    idle(2);
    check_next("expchg");
    chk("expchg_err_abs", last_got.err, 64'd1);

    // most negative inputs
    fill(FFT_LEN, 200, 1);
    si[7] = -32768; sq[7] = -32768;
    send_frame(FFT_LEN, 100, 'h10, 1'b1);
    idle(2);
    check_next("extreme");
    chk("extreme_pow_abs", last_got.pow, 64'h080000000);
    chk("extreme_idx_abs", last_got.idx, 64'd7);

    // reset in the middle of a frame
    fill(FFT_LEN, 200, 5);
    send_frame(400, 100, 'h30, 1'b0);
    bus.ival = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle(10);
    chk("midrst_no_strobe", 64'(got_q.size()), 64'd0);
    fill(FFT_LEN, 200, 12);
    si[77] = 9000;
    send_frame(FFT_LEN, 100, int'($urandom_range(255)), 1'b1);
    idle(2);
    check_next("postrst");
    chk("postrst_idx_abs", last_got.idx, 64'd77);
    chk("postrst_err_abs", last_got.err, 64'd0);

    idle(10);
    chk("no_extra_results", 64'(got_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
